// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: parity width, Hamming position map, encoder and syndrome classification.
package ecc_pkg;

    localparam int unsigned MAX_DW = 256;
    localparam int unsigned MAX_PW = 10;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_SBE  = 2'd1,
        ERR_DBE  = 2'd2
    } err_t;

    // Hamming bits R (smallest r with 2**r >= dw+r+1) plus the overall parity bit.
    function automatic int unsigned ecc_pw(input int unsigned dw);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < dw + r + 1) r++;
        return r + 1;
    endfunction

    // Position of data bit i: the i-th non-power-of-two position, starting at 3.
    function automatic int unsigned ecc_pos(input int unsigned i);
        int unsigned p;
        p = 3;
        for (int unsigned k = 0; k < i; k++) begin
            p++;
            if ((p & (p - 1)) == 0) p++;
        end
        return p;
    endfunction

    function automatic logic [MAX_PW-1:0] ecc_encode(input logic [MAX_DW-1:0] d, input int unsigned dw);
        int unsigned r;
        int unsigned p;
        logic [MAX_PW-1:0] chk;
        logic all;
        r   = ecc_pw(dw) - 1;
        chk = '0;
        all = 1'b0;
        p   = 2;
        for (int unsigned i = 0; i < dw; i++) begin
            p++;
            if ((p & (p - 1)) == 0) p++;
            all = all ^ d[8'(i)];
            for (int unsigned k = 0; k < r; k++) begin
                if (p[5'(k)]) chk[4'(k)] = chk[4'(k)] ^ d[8'(i)];
            end
        end
        for (int unsigned k = 0; k < r; k++) all = all ^ chk[4'(k)];
        chk = chk | (MAX_PW'(all) << r);
        return chk;
    endfunction

    function automatic err_t ecc_classify(input logic [MAX_PW-1:0] syn, input int unsigned dw);
        int unsigned r;
        logic [MAX_PW-1:0] low_mask;
        r        = ecc_pw(dw) - 1;
        low_mask = MAX_PW'((32'd1 << r) - 32'd1);
        if (|((syn >> r) & MAX_PW'(1))) return ERR_SBE;
        if (|(syn & low_mask)) return ERR_DBE;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/ecc_secded_core.sv
// Combinational SECDED encoder and syndrome generator for one word.
module ecc_secded_core
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 42,
    localparam int unsigned PARITY_WIDTH = ecc_pw(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [PARITY_WIDTH-1:0] parity,
    output logic [PARITY_WIDTH-1:0] check,
    output logic [PARITY_WIDTH-1:0] syn
);

    localparam int unsigned R = PARITY_WIDTH - 1;

    // Overall syndrome bit is parity over every received bit, so a flipped check bit reads as single.
    always_comb begin
        check = PARITY_WIDTH'(ecc_encode(MAX_DW'(data), DATA_WIDTH));
        syn   = {(^data) ^ (^parity), parity[R-1:0] ^ check[R-1:0]};
    end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage SECDED check/correct pipeline with error counters, first-error capture and irq.
module ecc_secded_pipe
    import ecc_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = 42,
    parameter  int unsigned ADDR_WIDTH   = 8,
    parameter  int unsigned CNT_WIDTH    = 16,
    localparam int unsigned PARITY_WIDTH = ecc_pw(DATA_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic [PARITY_WIDTH-1:0] in_parity,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    bypass,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [PARITY_WIDTH-1:0] out_parity,
    output logic                    out_sbit,
    output logic                    out_dbit,
    input  logic                    clr_stat,
    output logic [CNT_WIDTH-1:0]    sbe_cnt,
    output logic [CNT_WIDTH-1:0]    dbe_cnt,
    output logic [ADDR_WIDTH-1:0]   err_addr,
    output logic                    err_addr_vld,
    output logic                    err_is_dbe,
    output logic                    irq
);

    localparam int unsigned R = PARITY_WIDTH - 1;

    logic                    s1_vld;
    logic [DATA_WIDTH-1:0]   s1_data;
    logic [PARITY_WIDTH-1:0] s1_syn;
    logic [ADDR_WIDTH-1:0]   s1_addr;
    logic                    s1_bypass;

    logic                    s1_load;
    logic                    s2_load;
    err_t                    s1_err;
    logic [DATA_WIDTH-1:0]   flip;
    logic [DATA_WIDTH-1:0]   corr_data;
    logic [PARITY_WIDTH-1:0] in_syn;
    logic [PARITY_WIDTH-1:0] corr_check;
    logic [PARITY_WIDTH-1:0] unused_in_check;
    logic [PARITY_WIDTH-1:0] unused_corr_syn;
    logic                    count_sbe;
    logic                    count_dbe;

    logic [CNT_WIDTH-1:0]    sbe_nxt;
    logic [CNT_WIDTH-1:0]    dbe_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic                    addr_vld_nxt;
    logic                    is_dbe_nxt;
    logic                    irq_nxt;

    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_syn (
        .data   (in_data),
        .parity (in_parity),
        .check  (unused_in_check),
        .syn    (in_syn)
    );

    ecc_secded_core #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .data   (corr_data),
        .parity ('0),
        .check  (corr_check),
        .syn    (unused_corr_syn)
    );

    // Flip the data bit whose Hamming position matches a single-error syndrome.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_flip
        localparam int unsigned POS = ecc_pos(i);
        assign flip[i] = s1_syn[R] && (s1_syn[R-1:0] == R'(POS));
    end

    assign s2_load   = s1_vld && (!out_valid || out_ready);
    assign in_ready  = !s1_vld || s2_load;
    assign s1_load   = in_valid && in_ready;
    assign s1_err    = s1_bypass ? ERR_NONE : ecc_classify(MAX_PW'(s1_syn), DATA_WIDTH);
    assign corr_data = s1_bypass ? s1_data : (s1_data ^ flip);
    assign count_sbe = s2_load && (s1_err == ERR_SBE);
    assign count_dbe = s2_load && (s1_err == ERR_DBE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_data   <= '0;
            s1_syn    <= '0;
            s1_addr   <= '0;
            s1_bypass <= 1'b0;
        end else begin
            if (in_ready) s1_vld <= in_valid;
            if (s1_load) begin
                s1_data   <= in_data;
                s1_syn    <= in_syn;
                s1_addr   <= in_addr;
                s1_bypass <= bypass;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= '0;
            out_sbit   <= 1'b0;
            out_dbit   <= 1'b0;
        end else begin
            if (!out_valid || out_ready) out_valid <= s1_vld;
            if (s2_load) begin
                out_data   <= corr_data;
                out_parity <= corr_check;
                out_sbit   <= (s1_err == ERR_SBE);
                out_dbit   <= (s1_err == ERR_DBE);
            end
        end
    end

    // Clear applies first, then the error loading S2 this cycle is counted/captured.
    always_comb begin
        sbe_nxt      = clr_stat ? '0 : sbe_cnt;
        dbe_nxt      = clr_stat ? '0 : dbe_cnt;
        addr_nxt     = clr_stat ? '0 : err_addr;
        addr_vld_nxt = clr_stat ? 1'b0 : err_addr_vld;
        is_dbe_nxt   = clr_stat ? 1'b0 : err_is_dbe;
        irq_nxt      = clr_stat ? 1'b0 : irq;
        if (count_sbe && (sbe_nxt != '1)) sbe_nxt = sbe_nxt + CNT_WIDTH'(1);
        if (count_dbe && (dbe_nxt != '1)) dbe_nxt = dbe_nxt + CNT_WIDTH'(1);
        if ((count_sbe || count_dbe) && (!addr_vld_nxt || (count_dbe && !is_dbe_nxt))) begin
            addr_nxt     = s1_addr;
            addr_vld_nxt = 1'b1;
            is_dbe_nxt   = count_dbe;
        end
        if (count_dbe) irq_nxt = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbe_cnt      <= '0;
            dbe_cnt      <= '0;
            err_addr     <= '0;
            err_addr_vld <= 1'b0;
            err_is_dbe   <= 1'b0;
            irq          <= 1'b0;
        end else begin
            sbe_cnt      <= sbe_nxt;
            dbe_cnt      <= dbe_nxt;
            err_addr     <= addr_nxt;
            err_addr_vld <= addr_vld_nxt;
            err_is_dbe   <= is_dbe_nxt;
            irq          <= irq_nxt;
        end
    end

endmodule
